alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Alarm stage directly downstream of the time counter; consumes the live hour/minute/second buses.
- Holds a user-set alarm time and detects a match at second 0.
- Runs an IDLE/RINGING/SNOOZE state machine, drives a square-wave buzzer output, and supports a bounded number of snoozes.
- Its outputs feed the buzzer pin and the alarm LEDs/display mux.

Parameters:
- TONE_DIV, 50000, clk cycles per buzzer half-period (1 kHz at 100 MHz); min 1
- RING_SECONDS, 60, seconds of ringing before auto-off; 1..63
- SNOOZE_MIN, 5, minutes added per snooze; 1..59
- MAX_SNOOZE, 3, snoozes allowed per alarm event; 0..7
- RST_HOUR, 7, alarm hour after reset; 0..23
- RST_MIN, 0, alarm minute after reset; 0..59

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- hour  in  6  current hour 0..23 from time counter
- minute  in  6  current minute 0..59
- second  in  6  current second 0..59
- alarm_on  in  1  level; alarm armed when high
- set_en  in  1  level; alarm-set mode
- set_h  in  1  single-cycle debounced pulse; increments alarm hour when set_en=1
- set_min  in  1  single-cycle pulse; increments alarm minute when set_en=1
- snooze  in  1  single-cycle pulse
- stop  in  1  single-cycle pulse
- alarm_hour  out  6  stored alarm hour
- alarm_minute  out  6  stored alarm minute
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZE
- buzzer  out  1  tone output

Behaviour:
Reset (rst=0, async):
- alarm_hour=RST_HOUR, alarm_minute=RST_MIN.
- State=IDLE; ringing, snoozing and buzzer are 0.
- ring_cnt, snooze_cnt, tone counter and second_d are 0.
- Target is loaded from the alarm values.

Time inputs:
- second_d registers the previous second.
- sec_tick = (second != second_d), a one-cycle pulse.
- trigger = sec_tick && second==0 && hour==tgt_h && minute==tgt_m && alarm_on && !set_en.
- Fires exactly once per matching minute.

Set mode:
- set_h increments alarm_hour, wrapping 23->0; set_min increments alarm_minute, wrapping 59->0. Both act only while set_en=1.
- Pulses with set_en=0 are ignored.
- While set_en=1, the FSM is forced to IDLE next cycle and snooze_cnt=0.
- In IDLE, tgt_h/tgt_m continuously track alarm_hour/alarm_minute.

FSM (registered, 1-cycle latency from event to output):
- IDLE: on trigger -> RINGING; ring_cnt=0; tone counter starts.
- RINGING: ring_cnt += 1 on each sec_tick. Events are evaluated in this priority order:
  1. stop or !alarm_on -> IDLE, snooze_cnt=0.
  2. ring_cnt==RING_SECONDS-1 with sec_tick -> IDLE, snooze_cnt=0.
  3. snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+=1, target = current time + SNOOZE_MIN (see wrap rules).
- RINGING, snooze with snooze_cnt==MAX_SNOOZE: pulse ignored; ringing continues.
- SNOOZE:
  - stop or !alarm_on -> IDLE, snooze_cnt=0.
  - trigger on snooze target -> RINGING, ring_cnt=0.

Snooze target arithmetic:
- sum = {1'b0,minute} + SNOOZE_MIN, 7 bits.
- If sum>=60: tgt_m = sum-60 and tgt_h = hour+1, wrapping 23->0. Otherwise tgt_m = sum and tgt_h = hour.

Buzzer:
- In RINGING, the tone counter counts 0..TONE_DIV-1; buzzer toggles on terminal count.
- Outside RINGING, the counter and buzzer are held at 0.
- Buzzer is 0 on the cycle state leaves RINGING.

Boundary cases:
- trigger and stop in the same cycle in IDLE: enter RINGING. A stop is only meaningful while ringing.
- snooze and stop in the same cycle: stop wins.
- Time-counter reset mid-ring: the resulting second change counts as a sec_tick; no special handling.
- rst asserted mid-operation: immediate return to the reset values.

Test Plan:
1. Reset then idle: after reset, alarm 07:00, ringing=0, buzzer=0. Drive time 06:59:59 -> 07:00:00 -> ringing=1 one cycle after second becomes 0; buzzer toggles every TONE_DIV cycles (sim TONE_DIV=4).
2. Set mode: set_en=1, 17 set_h pulses from 07 -> alarm_hour=0 (wrap); 60 set_min pulses -> alarm_minute=0. Pulses with set_en=0 leave the values unchanged.
3. Snooze wrap: alarm 23:58, ring at 23:58:00, snooze at 23:58:10 -> snoozing=1, target 00:03. Drive 00:03:00 -> ringing=1.
4. Snooze limit: MAX_SNOOZE=3; snooze three times then press snooze a fourth time -> stays RINGING. Stop -> IDLE with snooze_cnt=0; the next day's alarm is again snoozable 3 times.
5. Auto-off: RING_SECONDS=60; ring from 07:00:00 with no input -> ringing=0 after the sec_tick at 07:01:00. No re-trigger during 07:00:xx.
6. Priority and disarm: stop+snooze in the same cycle -> IDLE. alarm_on=0 while SNOOZE -> IDLE, no ring at the target. rst=0 while RINGING -> buzzer=0 immediately (async).

Source files
------------

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: time-counter inputs, user controls and alarm outputs of the alarm stage.
interface alarm_ctrl_if;
    logic [5:0] hour_i, minute_i, second_i;
    logic       alarm_on_i, set_en_i, set_h_i, set_min_i, snooze_i, stop_i;
    logic [5:0] alarm_hour_o, alarm_minute_o;
    logic       ringing_o, snoozing_o, buzzer_o;
    modport master (
        output hour_i, minute_i, second_i, alarm_on_i, set_en_i, set_h_i, set_min_i, snooze_i, stop_i,
        input  alarm_hour_o, alarm_minute_o, ringing_o, snoozing_o, buzzer_o
    );
    modport slave (
        input  hour_i, minute_i, second_i, alarm_on_i, set_en_i, set_h_i, set_min_i, snooze_i, stop_i,
        output alarm_hour_o, alarm_minute_o, ringing_o, snoozing_o, buzzer_o
    );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: stored alarm time, match detection at second 0, IDLE/RINGING/SNOOZE FSM and buzzer tone.
module alarm_ctrl #(
    parameter int unsigned TONE_DIV     = 50000,
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned MAX_SNOOZE   = 3,
    parameter int unsigned RST_HOUR     = 7,
    parameter int unsigned RST_MIN      = 0
) (
    input logic         clk,
    input logic         rst_n,
    alarm_ctrl_if.slave bus
);
    localparam int unsigned TW = TONE_DIV > 1 ? $clog2(TONE_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
    state_t        state_q;
    logic [5:0]    alarm_hour_q, alarm_min_q, tgt_h_q, tgt_m_q, sec_prev_q, ring_cnt_q;
    logic [2:0]    snooze_cnt_q;
    logic [TW-1:0] tone_q;
    logic          ringing_q, snoozing_q, buzzer_q;
    logic          sec_tick, trigger, tone_tc, quit;
    logic [6:0]    snz_sum;
    logic [5:0]    snz_h, snz_m, alarm_hour_d, alarm_min_d;

    always_comb begin
        sec_tick     = bus.second_i != sec_prev_q;
        trigger      = sec_tick && bus.second_i == 6'd0 && bus.hour_i == tgt_h_q &&
                       bus.minute_i == tgt_m_q && bus.alarm_on_i && !bus.set_en_i;
        tone_tc      = tone_q == TW'(TONE_DIV - 1);
        quit         = bus.stop_i || !bus.alarm_on_i;
        snz_sum      = {1'b0, bus.minute_i} + 7'(SNOOZE_MIN);
        snz_m        = snz_sum >= 7'd60 ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
        snz_h        = snz_sum < 7'd60 ? bus.hour_i : bus.hour_i == 6'd23 ? 6'd0 : bus.hour_i + 6'd1;
        alarm_hour_d = bus.set_en_i && bus.set_h_i ?
                       (alarm_hour_q == 6'd23 ? 6'd0 : alarm_hour_q + 6'd1) : alarm_hour_q;
        alarm_min_d  = bus.set_en_i && bus.set_min_i ?
                       (alarm_min_q == 6'd59 ? 6'd0 : alarm_min_q + 6'd1) : alarm_min_q;
    end

    // Tone counter and buzzer default to 0; only a cycle that stays in RINGING advances them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alarm_hour_q <= 6'(RST_HOUR);
            alarm_min_q  <= 6'(RST_MIN);
            tgt_h_q      <= 6'(RST_HOUR);
            tgt_m_q      <= 6'(RST_MIN);
            sec_prev_q   <= '0;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            tone_q       <= '0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
            buzzer_q     <= 1'b0;
        end else begin
            sec_prev_q   <= bus.second_i;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            tone_q       <= '0;
            buzzer_q     <= 1'b0;
            if (bus.set_en_i) begin
                state_q      <= IDLE;
                ringing_q    <= 1'b0;
                snoozing_q   <= 1'b0;
                snooze_cnt_q <= '0;
                tgt_h_q      <= alarm_hour_q;
                tgt_m_q      <= alarm_min_q;
            end else begin
                case (state_q)
                    IDLE: begin
                        tgt_h_q <= alarm_hour_q;
                        tgt_m_q <= alarm_min_q;
                        if (trigger) begin
                            state_q    <= RINGING;
                            ringing_q  <= 1'b1;
                            ring_cnt_q <= '0;
                        end
                    end
                    RINGING: begin
                        ring_cnt_q <= ring_cnt_q + 6'(sec_tick);
                        if (quit || (sec_tick && ring_cnt_q == 6'(RING_SECONDS - 1))) begin
                            state_q      <= IDLE;
                            ringing_q    <= 1'b0;
                            snooze_cnt_q <= '0;
                        end else if (bus.snooze_i && snooze_cnt_q < 3'(MAX_SNOOZE)) begin
                            state_q      <= SNOOZE;
                            ringing_q    <= 1'b0;
                            snoozing_q   <= 1'b1;
                            snooze_cnt_q <= snooze_cnt_q + 3'd1;
                            tgt_h_q      <= snz_h;
                            tgt_m_q      <= snz_m;
                        end else begin
                            tone_q   <= tone_tc ? '0 : tone_q + TW'(1);
                            buzzer_q <= buzzer_q ^ tone_tc;
                        end
                    end
                    SNOOZE: begin
                        if (quit) begin
                            state_q      <= IDLE;
                            snoozing_q   <= 1'b0;
                            snooze_cnt_q <= '0;
                        end else if (trigger) begin
                            state_q    <= RINGING;
                            ringing_q  <= 1'b1;
                            snoozing_q <= 1'b0;
                            ring_cnt_q <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.alarm_hour_o   = alarm_hour_q;
    assign bus.alarm_minute_o = alarm_min_q;
    assign bus.ringing_o      = ringing_q;
    assign bus.snoozing_o     = snoozing_q;
    assign bus.buzzer_o       = buzzer_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: scenario tasks push expected {alarm_hour, alarm_minute, ringing, snoozing, buzzer} and pop after the DUT responds.
module tb_alarm_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [14:0] sb[$];
    string nm[$];
    logic [14:0] e;
    string n;

    alarm_ctrl_if bus();
    alarm_ctrl #(.TONE_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [14:0] pk(int h, int m, bit r, bit s, bit b);
        return {6'(h), 6'(m), r, s, b};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.alarm_hour_o, bus.alarm_minute_o, bus.ringing_o, bus.snoozing_o, bus.buzzer_o};
    endfunction

    task automatic push(logic [14:0] v, string s);
        sb.push_back(v);
        nm.push_back(s);
    endtask

    task automatic tick(int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_time(int h, int m, int s);
        bus.hour_i = 6'(h);
        bus.minute_i = 6'(m);
        bus.second_i = 6'(s);
    endtask

    task automatic pulse_h(int k);
        repeat (k) begin
            bus.set_h_i = 1'b1; tick(); bus.set_h_i = 1'b0; tick();
        end
    endtask

    task automatic pulse_m(int k);
        repeat (k) begin
            bus.set_min_i = 1'b1; tick(); bus.set_min_i = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        push(pk(7, 0, 0, 0, 0), "reset_hold"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        rst_n = 1'b1;
        push(pk(7, 0, 0, 0, 0), "post_reset"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
    endtask

    task automatic test_ring();
        set_time(6, 59, 59);
        push(pk(7, 0, 0, 0, 0), "pre_ring"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        set_time(7, 0, 0);
        push(pk(7, 0, 1, 0, 0), "ring_start"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        push(pk(7, 0, 1, 0, 0), "tone_low"); tick(3);
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        push(pk(7, 0, 1, 0, 1), "tone_rise"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        push(pk(7, 0, 1, 0, 1), "tone_hold"); tick(3);
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        push(pk(7, 0, 1, 0, 0), "tone_fall"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.stop_i = 1'b1;
        push(pk(7, 0, 0, 0, 0), "stop"); tick();
        bus.stop_i = 1'b0;
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        push(pk(7, 0, 0, 0, 0), "no_retrigger"); tick(2);
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
    endtask

    task automatic test_set();
        bus.set_en_i = 1'b1;
        pulse_h(17);
        push(pk(0, 0, 0, 0, 0), "hour_wrap"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        pulse_m(5);
        push(pk(0, 5, 0, 0, 0), "min_5"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        pulse_m(55);
        push(pk(0, 0, 0, 0, 0), "min_wrap"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.set_en_i = 1'b0;
        pulse_h(1);
        pulse_m(1);
        push(pk(0, 0, 0, 0, 0), "set_ignored"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.set_en_i = 1'b1;
        pulse_h(23);
        pulse_m(58);
        bus.set_en_i = 1'b0;
        push(pk(23, 58, 0, 0, 0), "set_2358"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
    endtask

    task automatic test_snooze_wrap();
        set_time(23, 57, 59); tick();
        set_time(23, 58, 0);
        push(pk(23, 58, 1, 0, 0), "ring_2358"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        for (int s = 1; s <= 10; s++) begin
            set_time(23, 58, s); tick();
        end
        bus.snooze_i = 1'b1;
        push(pk(23, 58, 0, 1, 0), "snooze_wrap"); tick();
        bus.snooze_i = 1'b0;
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        set_time(0, 1, 59); tick();
        set_time(0, 2, 0);
        push(pk(23, 58, 0, 1, 0), "no_early_ring"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        set_time(0, 2, 59); tick();
        set_time(0, 3, 0);
        push(pk(23, 58, 1, 0, 0), "wrap_target_ring"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.stop_i = 1'b1;
        push(pk(23, 58, 0, 0, 0), "wrap_stop"); tick();
        bus.stop_i = 1'b0;
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
    endtask

    task automatic test_snooze_limit();
        int h;
        int m;
        for (int d = 0; d < 2; d++) begin
            h = 23;
            m = 58;
            set_time(h, m, 59); tick();
            set_time(h, m, 0);
            push(pk(23, 58, 1, 0, 0), $sformatf("day%0d_ring", d)); tick();
            e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
            for (int k = 0; k < 3; k++) begin
                bus.snooze_i = 1'b1;
                push(pk(23, 58, 0, 1, 0), $sformatf("day%0d_snooze%0d", d, k)); tick();
                bus.snooze_i = 1'b0;
                e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
                m += 5;
                if (m >= 60) begin
                    m -= 60;
                    h = (h + 1) % 24;
                end
                set_time(h, m, 59); tick();
                set_time(h, m, 0);
                push(pk(23, 58, 1, 0, 0), $sformatf("day%0d_rering%0d", d, k)); tick();
                e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
            end
            bus.snooze_i = 1'b1;
            push(pk(23, 58, 1, 0, 0), $sformatf("day%0d_snooze_limit", d)); tick();
            bus.snooze_i = 1'b0;
            e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
            bus.stop_i = 1'b1;
            push(pk(23, 58, 0, 0, 0), $sformatf("day%0d_stop", d)); tick();
            bus.stop_i = 1'b0;
            e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        end
    endtask

    task automatic test_auto_off();
        bus.set_en_i = 1'b1;
        pulse_h(8);
        pulse_m(2);
        bus.set_en_i = 1'b0;
        push(pk(7, 0, 0, 0, 0), "back_to_0700"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        set_time(6, 59, 59); tick();
        set_time(7, 0, 0);
        push(pk(7, 0, 1, 0, 0), "auto_ring"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        for (int s = 1; s < 59; s++) begin
            set_time(7, 0, s); tick();
        end
        set_time(7, 0, 59);
        push(pk(7, 0, 1, 0, (59 / 4) % 2 == 1), "ring_at_59s"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        set_time(7, 1, 0);
        push(pk(7, 0, 0, 0, 0), "auto_off"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
    endtask

    task automatic test_priority();
        set_time(6, 59, 59); tick();
        set_time(7, 0, 0);
        push(pk(7, 0, 1, 0, 0), "prio_ring"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.stop_i = 1'b1;
        bus.snooze_i = 1'b1;
        push(pk(7, 0, 0, 0, 0), "stop_beats_snooze"); tick();
        bus.stop_i = 1'b0;
        bus.snooze_i = 1'b0;
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        set_time(6, 59, 59); tick();
        set_time(7, 0, 0);
        bus.stop_i = 1'b1;
        push(pk(7, 0, 1, 0, 0), "trigger_with_stop"); tick();
        bus.stop_i = 1'b0;
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.snooze_i = 1'b1;
        push(pk(7, 0, 0, 1, 0), "prio_snooze"); tick();
        bus.snooze_i = 1'b0;
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.alarm_on_i = 1'b0;
        push(pk(7, 0, 0, 0, 0), "disarm_snooze"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        set_time(7, 4, 59); tick();
        set_time(7, 5, 0);
        push(pk(7, 0, 0, 0, 0), "no_ring_disarmed"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        bus.alarm_on_i = 1'b1;
    endtask

    task automatic test_async_reset();
        bus.set_en_i = 1'b1;
        pulse_h(1);
        bus.set_en_i = 1'b0;
        tick();
        set_time(7, 59, 59); tick();
        set_time(8, 0, 0);
        push(pk(8, 0, 1, 0, 0), "ring_0800"); tick();
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        push(pk(8, 0, 1, 0, 1), "buzz_before_rst"); tick(4);
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        #2;
        rst_n = 1'b0;
        push(pk(7, 0, 0, 0, 0), "async_rst");
        #1;
        e = sb.pop_front(); n = nm.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL %s got=%h want=%h", n, obs(), e); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        set_time(6, 59, 58);
        bus.alarm_on_i = 1'b1;
        bus.set_en_i = 1'b0;
        bus.set_h_i = 1'b0;
        bus.set_min_i = 1'b0;
        bus.snooze_i = 1'b0;
        bus.stop_i = 1'b0;
        test_reset();
        test_ring();
        test_set();
        test_snooze_wrap();
        test_snooze_limit();
        test_auto_off();
        test_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
